gate_cluster_multi: RTL and testbench

- Parametrised gate cluster for the wiring simulator. Merges a bank of LAMP_COUNT toggle lamps with one configurable logic gate.
- Adds three behaviours to the single-mode, fixed-width gates:
  - output only on a change of gate state;
  - a fire-once-per-logic-pass rule;
  - counting of blocked triggers.
- Sits between the wire-input fabric and downstream output/gate cells. Its out feeds other cells' in buses.

---
 rtl/gate_cluster_multi.sv | 94 +++++++++
 tb/tb_gate_cluster_multi.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/gate_cluster_multi.sv
// Gate cluster: a bank of toggle lamps feeding one configurable gate, pulsing out on gate change.
// Latency: input pulse in cycle t -> lamp update at t+1 -> out/blocked pulse during t+2.
// No backpressure: a new input vector is accepted every cycle and never stalls.
module gate_cluster_multi #(
  parameter int                    LAMP_COUNT      = 4,
  parameter int                    INPUTS_PER_LAMP = 2,
  parameter int                    GATE_MODE       = 0,
  parameter logic [LAMP_COUNT-1:0] LAMP_INIT       = '0,
  parameter int                    CNT_WIDTH       = 8
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  logic_reset,
  input  logic [LAMP_COUNT*INPUTS_PER_LAMP-1:0] in,
  output logic                                  out,
  output logic                                  gate_state,
  output logic [LAMP_COUNT-1:0]                 lamp_state,
  output logic                                  blocked,
  output logic [CNT_WIDTH-1:0]                  blocked_count,
  output logic                                  busy
);

  // Gate function over the lamp vector; modes 6/7 fall back to AND.
  function automatic logic gate_fn(input logic [LAMP_COUNT-1:0] lamps);
    int  ones;
    logic one_on;
    ones = 0;
    for (int i = 0; i < LAMP_COUNT; i++) begin
      if (lamps[i]) ones = ones + 1;
    end
    one_on = (ones == 1);
    case (GATE_MODE)
      1:       gate_fn = |lamps;
      2:       gate_fn = ~(&lamps);
      3:       gate_fn = ~(|lamps);
      4:       gate_fn = one_on;
      5:       gate_fn = ~one_on;
      default: gate_fn = &lamps;
    endcase
  endfunction

  logic [LAMP_COUNT-1:0] toggle;
  logic                  lamp_chg;
  logic                  fired;
  logic                  fired_eff;
  logic                  g_new;

  // Per-lamp toggle: odd number of simultaneous pulses flips the lamp.
  always_comb begin
    toggle = '0;
    for (int i = 0; i < LAMP_COUNT; i++) begin
      toggle[i] = ^in[i*INPUTS_PER_LAMP +: INPUTS_PER_LAMP];
    end
  end

  // Evaluate the gate on the current lamps; logic_reset re-arms firing before this evaluation.
  always_comb begin
    g_new     = gate_fn(lamp_state);
    fired_eff = fired & ~logic_reset;
    busy      = (|in) | lamp_chg | out | blocked;
  end

  // Lamp register, gate register, fire-once bookkeeping and blocked counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      lamp_state    <= LAMP_INIT;
      gate_state    <= gate_fn(LAMP_INIT);
      lamp_chg      <= 1'b0;
      fired         <= 1'b0;
      out           <= 1'b0;
      blocked       <= 1'b0;
      blocked_count <= '0;
    end else begin
      lamp_state <= lamp_state ^ toggle;
      lamp_chg   <= |toggle;
      gate_state <= g_new;
      out        <= 1'b0;
      blocked    <= 1'b0;
      fired      <= fired_eff;
      if (g_new != gate_state) begin
        if (!fired_eff) begin
          out   <= 1'b1;
          fired <= 1'b1;
        end else begin
          blocked <= 1'b1;
          if (blocked_count != {CNT_WIDTH{1'b1}}) begin
            blocked_count <= blocked_count + CNT_WIDTH'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_gate_cluster_multi.sv
module tb_gate_cluster_multi;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       lr_a = 1'b0;
  logic       lr_x = 1'b0;
  logic [7:0] in_a = '0;
  logic [7:0] in_x = '0;

  logic       out_a, gate_a, blk_a, busy_a;
  logic [3:0] lamp_a;
  logic [1:0] cnt_a;
  logic       out_x, gate_x, blk_x, busy_x;
  logic [3:0] lamp_x;
  logic [7:0] cnt_x;

  int ntests = 0;
  int nfail  = 0;

  always #5 clk = ~clk;

  // AND gate with a narrow counter so saturation is reachable.
  gate_cluster_multi #(.LAMP_COUNT(4), .INPUTS_PER_LAMP(2), .GATE_MODE(0),
                       .LAMP_INIT(4'b0000), .CNT_WIDTH(2)) u_and (
    .clk(clk), .reset(reset), .logic_reset(lr_a), .in(in_a),
    .out(out_a), .gate_state(gate_a), .lamp_state(lamp_a),
    .blocked(blk_a), .blocked_count(cnt_a), .busy(busy_a));

  // XOR (exactly-one) gate.
  gate_cluster_multi #(.LAMP_COUNT(4), .INPUTS_PER_LAMP(2), .GATE_MODE(4),
                       .LAMP_INIT(4'b0000), .CNT_WIDTH(8)) u_xor (
    .clk(clk), .reset(reset), .logic_reset(lr_x), .in(in_x),
    .out(out_x), .gate_state(gate_x), .lamp_state(lamp_x),
    .blocked(blk_x), .blocked_count(cnt_x), .busy(busy_x));

  task automatic chk(input string name, input int act, input int exp);
    ntests++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit rst, input bit la, input logic [7:0] ia,
                       input bit lx, input logic [7:0] ix);
    @(negedge clk);
    reset = rst; lr_a = la; in_a = ia; lr_x = lx; in_x = ix;
    #1;
  endtask

  // Directed vector table for the AND instance: one row per cycle.
  typedef struct {
    bit         rst;
    bit         lr;
    logic [7:0] in;
    bit         chk;
    logic [3:0] lamp;
    bit         gate;
    bit         out;
    bit         blk;
    int         cnt;
    bit         busy;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit rst, input bit lr, input logic [7:0] in, input bit c,
                     input logic [3:0] lamp, input bit gate, input bit out,
                     input bit blk, input int cnt, input bit busy);
    vec_t v;
    v.rst = rst; v.lr = lr; v.in = in; v.chk = c; v.lamp = lamp; v.gate = gate;
    v.out = out; v.blk = blk; v.cnt = cnt; v.busy = busy;
    vecs.push_back(v);
  endtask

  // Behavioural reference: lamps as integers, gate from a ones-count rule.
  typedef struct {
    int lamp;
    bit gate;
    bit fired;
    bit out;
    bit blk;
    int cnt;
    bit chg;
  } mdl_t;
  mdl_t m[2];
  int   mode[2] = '{0, 4};
  int   cmax[2] = '{3, 255};

  function automatic bit gate_ref(input int md, input int lamps);
    int ones;
    ones = $countones(lamps[3:0]);
    case (md)
      1:       return ones > 0;
      2:       return ones != 4;
      3:       return ones == 0;
      4:       return ones == 1;
      5:       return ones != 1;
      default: return ones == 4;
    endcase
  endfunction

  function automatic mdl_t model_step(input mdl_t s, input int md, input int cm,
                                      input bit rst, input bit lr, input logic [7:0] iv);
    mdl_t n;
    int   nl;
    bit   g;
    bit   fe;
    if (rst) begin
      n.lamp = 0; n.gate = gate_ref(md, 0); n.fired = 0;
      n.out = 0; n.blk = 0; n.cnt = 0; n.chg = 0;
      return n;
    end
    nl = s.lamp;
    for (int j = 0; j < 4; j++) begin
      if ($countones(iv[j*2 +: 2]) % 2 == 1) nl = nl ^ (1 << j);
    end
    g  = gate_ref(md, s.lamp);
    fe = lr ? 1'b0 : s.fired;
    n = s;
    n.out = 0; n.blk = 0; n.fired = fe;
    if (g != s.gate) begin
      if (!fe) begin
        n.out = 1; n.fired = 1;
      end else begin
        n.blk = 1;
        n.cnt = (s.cnt < cm) ? s.cnt + 1 : cm;
      end
    end
    n.gate = g;
    n.chg  = (nl != s.lamp);
    n.lamp = nl;
    return n;
  endfunction

  initial begin
    // rst lr in chk lamp gate out blk cnt busy
    add(1, 0, 8'h00, 0, 4'h0, 0, 0, 0, 0, 0);
    add(0, 0, 8'h00, 1, 4'h0, 0, 0, 0, 0, 0);  // reset state
    add(0, 0, 8'h55, 1, 4'h0, 0, 0, 0, 0, 1);  // all four lamps pulsed
    add(0, 0, 8'h00, 1, 4'hF, 0, 0, 0, 0, 1);
    add(0, 0, 8'h00, 1, 4'hF, 1, 1, 0, 0, 1);  // gate rises, fires
    add(0, 0, 8'h00, 1, 4'hF, 1, 0, 0, 0, 0);
    add(0, 0, 8'h01, 1, 4'hF, 1, 0, 0, 0, 1);  // lamp 0 off, same pass
    add(0, 0, 8'h00, 1, 4'hE, 1, 0, 0, 0, 1);
    add(0, 0, 8'h00, 1, 4'hE, 0, 0, 1, 1, 1);  // blocked
    add(0, 1, 8'h01, 1, 4'hE, 0, 0, 0, 1, 1);  // new pass + toggle
    add(0, 0, 8'h00, 1, 4'hF, 0, 0, 0, 1, 1);
    add(0, 0, 8'h00, 1, 4'hF, 1, 1, 0, 1, 1);  // fires again
    add(0, 0, 8'h03, 1, 4'hF, 1, 0, 0, 1, 1);  // even pulses on lamp 0
    add(0, 0, 8'h00, 1, 4'hF, 1, 0, 0, 1, 0);  // busy only one cycle
    add(0, 0, 8'h01, 1, 4'hF, 1, 0, 0, 1, 1);  // back-to-back toggles
    add(0, 0, 8'h01, 1, 4'hE, 1, 0, 0, 1, 1);
    add(0, 0, 8'h01, 1, 4'hF, 0, 0, 1, 2, 1);
    add(0, 0, 8'h01, 1, 4'hE, 1, 0, 1, 3, 1);
    add(0, 0, 8'h01, 1, 4'hF, 0, 0, 1, 3, 1);  // saturated
    add(0, 0, 8'h00, 1, 4'hE, 1, 0, 1, 3, 1);
    add(0, 0, 8'h00, 1, 4'hE, 0, 0, 1, 3, 1);
    add(0, 0, 8'h00, 1, 4'hE, 0, 0, 0, 3, 0);
    add(0, 0, 8'h01, 1, 4'hE, 0, 0, 0, 3, 1);  // triggering input
    add(1, 1, 8'h04, 1, 4'hF, 0, 0, 0, 3, 1);  // reset right after it
    add(0, 0, 8'h00, 1, 4'h0, 0, 0, 0, 0, 0);  // pulse discarded

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].lr, vecs[k].in, 1'b0, 8'h00);
      if (vecs[k].chk) begin
        chk($sformatf("vec%0d.lamp", k), lamp_a, vecs[k].lamp);
        chk($sformatf("vec%0d.gate", k), gate_a, vecs[k].gate);
        chk($sformatf("vec%0d.out", k), out_a, vecs[k].out);
        chk($sformatf("vec%0d.blocked", k), blk_a, vecs[k].blk);
        chk($sformatf("vec%0d.count", k), cnt_a, vecs[k].cnt);
        chk($sformatf("vec%0d.busy", k), busy_a, vecs[k].busy);
      end
    end

    // XOR instance: fire, re-fire after logic_reset, then blocked.
    chk("xor.reset_gate", gate_x, 0);
    drive(0, 0, 8'h00, 0, 8'h01);
    drive(0, 0, 8'h00, 0, 8'h00);
    chk("xor.lamp1", lamp_x, 4'b0001);
    drive(0, 0, 8'h00, 0, 8'h00);
    chk("xor.out1", out_x, 1);
    chk("xor.gate1", gate_x, 1);
    drive(0, 0, 8'h00, 1, 8'h04);
    chk("xor.out1_end", out_x, 0);
    drive(0, 0, 8'h00, 0, 8'h00);
    chk("xor.lamp2", lamp_x, 4'b0011);
    drive(0, 0, 8'h00, 0, 8'h00);
    chk("xor.out2", out_x, 1);
    chk("xor.gate2", gate_x, 0);
    drive(0, 0, 8'h00, 0, 8'h04);
    drive(0, 0, 8'h00, 0, 8'h00);
    drive(0, 0, 8'h00, 0, 8'h00);
    chk("xor.out3", out_x, 0);
    chk("xor.blocked3", blk_x, 1);
    chk("xor.gate3", gate_x, 1);
    chk("xor.count3", cnt_x, 1);

    // Randomised run against the reference model, both instances.
    for (int c = 0; c < 600; c++) begin
      bit         r, la, lx;
      logic [7:0] ia, ix;
      r  = (c == 0) || ($urandom_range(0, 59) == 0);
      la = ($urandom_range(0, 7) == 0);
      lx = ($urandom_range(0, 7) == 0);
      ia = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      ix = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      drive(r, la, ia, lx, ix);
      if (c > 0) begin
        chk("rnd.and.lamp", lamp_a, m[0].lamp);
        chk("rnd.and.gate", gate_a, m[0].gate);
        chk("rnd.and.out", out_a, m[0].out);
        chk("rnd.and.blocked", blk_a, m[0].blk);
        chk("rnd.and.count", cnt_a, m[0].cnt);
        chk("rnd.and.busy", busy_a, (ia != 0) || m[0].chg || m[0].out || m[0].blk);
        chk("rnd.xor.lamp", lamp_x, m[1].lamp);
        chk("rnd.xor.gate", gate_x, m[1].gate);
        chk("rnd.xor.out", out_x, m[1].out);
        chk("rnd.xor.blocked", blk_x, m[1].blk);
        chk("rnd.xor.count", cnt_x, m[1].cnt);
        chk("rnd.xor.busy", busy_x, (ix != 0) || m[1].chg || m[1].out || m[1].blk);
      end
      m[0] = model_step(m[0], mode[0], cmax[0], r, la, ia);
      m[1] = model_step(m[1], mode[1], cmax[1], r, lx, ix);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
